// File: rtl/result_pack_pkg.sv
// result_pack_pkg: shared defaults, FSM state encoding and lane-index width helper
package result_pack_pkg;
  localparam int IMG_WIDTH_DEF = 16;
  localparam int DEPTH_NB_DEF = 1;
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
  function automatic int clog2(input int n);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/result_pack_shift.sv
// result_pack_shift: N-lane accumulate register with lane write, clear and merged flush view
module result_pack_shift #(
  parameter int W = 16,
  parameter int N = 4,
  parameter int LW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   din,
  input  logic [LW-1:0]  lane,
  input  logic           wr,
  input  logic           clr,
  output logic [N*W-1:0] word
);
  logic [N*W-1:0] acc;
  assign word = acc | ((N*W)'(din) << (lane * W));
  always_ff @(posedge clk)
    if (rst || clr) acc <= '0;
    else if (wr) acc[lane*W +: W] <= din;
endmodule

// File: rtl/result_pack.sv
// result_pack: packs result beats into bus words framed by a configured beat count
module result_pack import result_pack_pkg::*; #(
  parameter int DEPTH_NB = DEPTH_NB_DEF,
  parameter int IMG_WIDTH = IMG_WIDTH_DEF,
  parameter int BUS_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   cfg_count,
  input  logic                          cfg_val,
  output logic                          cfg_rdy,
  input  logic [IMG_WIDTH*DEPTH_NB-1:0] result,
  input  logic                          result_val,
  output logic                          result_rdy,
  output logic [BUS_WIDTH-1:0]          str_data,
  output logic                          str_last,
  output logic                          str_val,
  input  logic                          str_rdy,
  output logic                          done
);
  localparam int W = IMG_WIDTH * DEPTH_NB;
  localparam int PACK_NB = BUS_WIDTH / W;
  localparam int LW = clog2(PACK_NB) < 1 ? 1 : clog2(PACK_NB);
  state_t state, state_n;
  logic [31:0] count, beat_cnt;
  logic [LW-1:0] lane;
  logic [BUS_WIDTH-1:0] word;
  logic last_beat, complete, acc, start, fin;
  assign last_beat = beat_cnt == count - 32'd1;
  assign complete = lane == LW'(PACK_NB - 1) || last_beat;
  assign cfg_rdy = state == IDLE && !rst;
  assign result_rdy = state == ACTIVE && !rst && (!complete || !str_val || str_rdy);
  assign acc = result_val && result_rdy;
  assign start = cfg_val && cfg_rdy;
  assign fin = state == DRAIN && str_val && str_rdy && str_last;
  always_comb
    state_n = start && cfg_count != 32'd0 ? ACTIVE :
              acc && last_beat ? DRAIN :
              fin ? IDLE : state;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_ff @(posedge clk)
    if (rst) begin
      count <= '0;
      beat_cnt <= '0;
      lane <= '0;
    end else if (start) begin
      count <= cfg_count;
      beat_cnt <= '0;
      lane <= '0;
    end else if (acc) begin
      beat_cnt <= beat_cnt + 32'd1;
      lane <= complete ? '0 : lane + 1'b1;
    end
  always_ff @(posedge clk)
    if (rst) begin
      str_data <= '0;
      str_last <= 1'b0;
      str_val <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= fin || (start && cfg_count == 32'd0);
      if (acc && complete) begin
        str_data <= word;
        str_last <= last_beat;
        str_val <= 1'b1;
      end else if (str_rdy) str_val <= 1'b0;
    end
  result_pack_shift #(.W(W), .N(PACK_NB), .LW(LW)) u_shift (
    .clk(clk),
    .rst(rst),
    .din(result),
    .lane(lane),
    .wr(acc && !complete),
    .clr(start || (acc && complete)),
    .word(word)
  );
endmodule
